// File: rtl/clk_gen_pkg.sv
// Shared definitions for the clock-enable generator: channel state encoding
// and the width helper for the per-channel lock counter.
package clk_gen_pkg;

    typedef enum logic [1:0] {
        CH_OFF    = 2'd0,
        CH_SYNC   = 2'd1,
        CH_LOCKED = 2'd2
    } ch_state_e;

    // Lock counter must hold values 0..lock_ticks.
    function automatic int lock_cnt_w(input int lock_ticks);
        return (lock_ticks < 1) ? 1 : $clog2(lock_ticks + 1);
    endfunction

endpackage

// File: rtl/clk_enable_ch.sv
// One enable channel: divide counter, OFF/SYNC/LOCKED state machine and the
// tick/square decode. Reconfigured only through a one-cycle i_apply strobe.
module clk_enable_ch
    import clk_gen_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int LOCK_TICKS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_apply,
    input  logic [DIV_W-1:0] i_div,
    input  logic [DIV_W-1:0] i_phase,
    output logic             o_tick,
    output logic             o_square,
    output logic [1:0]       o_state
);

    localparam int LCW = lock_cnt_w(LOCK_TICKS);

    ch_state_e        r_state;
    ch_state_e        w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_nxt;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [LCW-1:0]   r_lock_cnt;
    logic [LCW-1:0]   w_lock_cnt_nxt;
    logic             w_wrap;
    logic [DIV_W:0]   w_half;

    assign w_wrap = (r_state != CH_OFF) && (r_cnt == (r_div - DIV_W'(1)));
    // One extra bit so div+1 cannot overflow for the largest divide ratio.
    assign w_half = ({1'b0, r_div} + (DIV_W+1)'(1)) >> 1;

    always_comb begin
        w_state_nxt    = r_state;
        w_div_nxt      = r_div;
        w_cnt_nxt      = r_cnt;
        w_lock_cnt_nxt = r_lock_cnt;
        if (i_apply) begin
            w_div_nxt      = i_div;
            w_cnt_nxt      = (i_phase < i_div) ? i_phase : '0;
            w_lock_cnt_nxt = '0;
            w_state_nxt    = (i_div != '0) ? CH_SYNC : CH_OFF;
        end else if (r_state != CH_OFF) begin
            if (w_wrap) begin
                w_cnt_nxt = '0;
                if (r_state == CH_SYNC) begin
                    w_lock_cnt_nxt = r_lock_cnt + LCW'(1);
                    if (r_lock_cnt == LCW'(LOCK_TICKS - 1)) begin
                        w_state_nxt = CH_LOCKED;
                    end
                end
            end else begin
                w_cnt_nxt = r_cnt + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= CH_OFF;
            r_div      <= '0;
            r_cnt      <= '0;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_div      <= w_div_nxt;
            r_cnt      <= w_cnt_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    assign o_tick   = w_wrap;
    assign o_square = (r_state != CH_OFF) && ({1'b0, r_cnt} < w_half);
    assign o_state  = r_state;

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator. Holds a single pending configuration
// slot and releases it to the target channel at that channel's next wrap.
module clk_enable_gen
    import clk_gen_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DIV_W      = 16,
    parameter int LOCK_TICKS = 8
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        cfg_valid,
    output logic                                        cfg_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [DIV_W-1:0]                            cfg_div,
    input  logic [DIV_W-1:0]                            cfg_phase,
    output logic [NUM_CH-1:0]                           tick,
    output logic [NUM_CH-1:0]                           square,
    output logic [NUM_CH-1:0]                           locked,
    output logic                                        all_locked
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // Handshake: a request transfers on any cycle with cfg_valid && cfg_ready;
    // cfg_ready stays low while the slot holds an unapplied request.
    logic             r_pend_valid;
    logic [CH_W-1:0]  r_pend_ch;
    logic [DIV_W-1:0] r_pend_div;
    logic [DIV_W-1:0] r_pend_phase;

    logic              w_xfer;
    logic              w_tgt_in_range;
    logic              w_tgt_ready;
    logic              w_apply_now;
    logic [NUM_CH-1:0] w_apply;
    logic [NUM_CH-1:0] w_tick;
    logic [NUM_CH-1:0] w_square;
    logic [NUM_CH-1:0] w_off;
    logic [NUM_CH-1:0] w_locked;
    logic [1:0]        w_ch_state [NUM_CH];

    assign cfg_ready      = !r_pend_valid;
    assign w_xfer         = cfg_valid && cfg_ready;
    assign w_tgt_in_range = (int'(r_pend_ch) < NUM_CH);
    // Out-of-range targets are released at once so the slot cannot stall.
    assign w_tgt_ready    = !w_tgt_in_range || w_off[r_pend_ch] || w_tick[r_pend_ch];
    assign w_apply_now    = r_pend_valid && w_tgt_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend_valid <= 1'b0;
            r_pend_ch    <= '0;
            r_pend_div   <= '0;
            r_pend_phase <= '0;
        end else begin
            if (w_apply_now) begin
                r_pend_valid <= 1'b0;
            end
            if (w_xfer) begin
                r_pend_valid <= 1'b1;
                r_pend_ch    <= cfg_ch;
                r_pend_div   <= cfg_div;
                r_pend_phase <= cfg_phase;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_apply[g] = w_apply_now && (r_pend_ch == CH_W'(g));

        clk_enable_ch #(
            .DIV_W      (DIV_W),
            .LOCK_TICKS (LOCK_TICKS)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_apply  (w_apply[g]),
            .i_div    (r_pend_div),
            .i_phase  (r_pend_phase),
            .o_tick   (w_tick[g]),
            .o_square (w_square[g]),
            .o_state  (w_ch_state[g])
        );

        assign w_off[g]    = (w_ch_state[g] == CH_OFF);
        assign w_locked[g] = (w_ch_state[g] == CH_LOCKED);
    end

    assign tick       = w_tick;
    assign square     = w_square;
    assign locked     = w_locked;
    assign all_locked = (|(~w_off)) && (&(w_locked | w_off));

endmodule

// File: tb/tb_clk_enable_gen.sv
// Bench for clk_enable_gen: closed-form channel model checked every cycle,
// plus directed scenarios with hand-derived output sequences.
module tb_clk_enable_gen;

    localparam int NUM_CH     = 4;
    localparam int DIV_W      = 16;
    localparam int LOCK_TICKS = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [1:0]        cfg_ch = '0;
    logic [DIV_W-1:0]  cfg_div = '0;
    logic [DIV_W-1:0]  cfg_phase = '0;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] square;
    logic [NUM_CH-1:0] locked;
    logic              all_locked;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    clk_enable_gen #(
        .NUM_CH     (NUM_CH),
        .DIV_W      (DIV_W),
        .LOCK_TICKS (LOCK_TICKS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_div    (cfg_div),
        .cfg_phase  (cfg_phase),
        .tick       (tick),
        .square     (square),
        .locked     (locked),
        .all_locked (all_locked)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: after an apply at cycle t0 a channel's position is phase+(t-t0);
    // counter = pos % div, completed wraps = pos / div.
    bit     m_live = 1'b0;
    longint cyc = 0;
    bit     m_on  [NUM_CH];
    int     m_div [NUM_CH];
    int     m_ph  [NUM_CH];
    longint m_t0  [NUM_CH];
    bit     m_pend = 1'b0;
    int     m_pch, m_pdiv, m_pph;

    function automatic longint m_pos(input int i);
        return longint'(m_ph[i]) + (cyc - m_t0[i]);
    endfunction

    function automatic logic [NUM_CH-1:0] exp_tick();
        logic [NUM_CH-1:0] v = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (m_on[i]) v[i] = ((m_pos(i) % m_div[i]) == m_div[i] - 1);
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_square();
        logic [NUM_CH-1:0] v = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (m_on[i]) v[i] = ((m_pos(i) % m_div[i]) < (m_div[i] + 1) / 2);
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_locked();
        logic [NUM_CH-1:0] v = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (m_on[i]) v[i] = ((m_pos(i) / m_div[i]) >= LOCK_TICKS);
        return v;
    endfunction

    function automatic logic exp_all_locked();
        logic [NUM_CH-1:0] l = exp_locked();
        bit any_on = 1'b0;
        bit all_ok = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_on[i]) begin
                any_on = 1'b1;
                if (!l[i]) all_ok = 1'b0;
            end
        end
        return any_on && all_ok;
    endfunction

    always @(negedge clk) begin : compare
        bit rdy;
        if (m_live) begin
            check("cmp_tick", 32'(tick), 32'(exp_tick()));
            check("cmp_square", 32'(square), 32'(exp_square()));
            check("cmp_locked", 32'(locked), 32'(exp_locked()));
            check("cmp_all_locked", 32'(all_locked), 32'(exp_all_locked()));
            check("cmp_cfg_ready", 32'(cfg_ready), 32'(!m_pend));
        end
        if (rst_n === 1'b0) begin
            m_live = 1'b1;
            m_pend = 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_on[i] = 1'b0; m_div[i] = 0; m_ph[i] = 0; m_t0[i] = 0;
            end
        end else if (m_live) begin
            rdy = !m_pend;
            if (m_pend) begin
                bit go;
                go = 1'b0;
                if (m_pch >= NUM_CH) go = 1'b1;
                else if (!m_on[m_pch]) go = 1'b1;
                else if ((m_pos(m_pch) % m_div[m_pch]) == m_div[m_pch] - 1) go = 1'b1;
                if (go) begin
                    if (m_pch < NUM_CH) begin
                        m_on[m_pch]  = (m_pdiv != 0);
                        m_div[m_pch] = m_pdiv;
                        m_ph[m_pch]  = (m_pph < m_pdiv) ? m_pph : 0;
                        m_t0[m_pch]  = cyc + 1;
                    end
                    m_pend = 1'b0;
                end
            end
            if (rdy && cfg_valid === 1'b1) begin
                m_pend = 1'b1;
                m_pch  = int'(cfg_ch);
                m_pdiv = int'(cfg_div);
                m_pph  = int'(cfg_phase);
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input int div, input int ph);
        int n = 0;
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_div   = DIV_W'(div);
        cfg_phase = DIV_W'(ph);
        while (1) begin
            @(negedge clk);
            if (cfg_ready === 1'b1) break;
            n++;
            if (n > 200) begin
                n_checks++;
                n_errors++;
                $display("FAIL send_timeout: ch %0d never accepted", ch);
                cfg_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_tick(input int ch);
        for (int n = 0; n < 40; n++) begin
            if (tick[ch] === 1'b1) return;
            step();
        end
        n_checks++;
        n_errors++;
        $display("FAIL wait_tick_timeout: ch %0d got no tick", ch);
    endtask

    initial begin : main
        logic [7:0] v_t;
        logic [7:0] v_s;
        logic [7:0] v_r;
        logic [7:0] v_l;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_square", 32'(square), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_all_locked", 32'(all_locked), 32'h0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'h1);

        // ch0 div=4 from OFF: applies the cycle after transfer
        send(0, 4, 0);
        check("a_ready_busy", 32'(cfg_ready), 32'h0);
        step();
        v_t = '0; v_s = '0;
        for (int k = 0; k < 8; k++) begin
            v_t[k] = tick[0];
            v_s[k] = square[0];
            step();
        end
        check("a_tick_seq", 32'(v_t), 32'h88);
        check("a_square_seq", 32'(v_s), 32'h33);
        repeat (23) step();
        check("a_locked_before", 32'(locked[0]), 32'h0);
        step();
        check("a_locked_after", 32'(locked[0]), 32'h1);
        check("a_all_locked", 32'(all_locked), 32'h1);

        // ch1 div=5 locked, then div=3 phase=1 accepted at cnt==1
        send(1, 5, 0);
        repeat (45) step();
        wait_tick(1);
        step();
        step();
        send(1, 3, 1);
        v_t = '0; v_s = '0; v_r = '0; v_l = '0;
        for (int k = 0; k < 5; k++) begin
            v_t[k] = tick[1];
            v_s[k] = square[1];
            v_r[k] = cfg_ready;
            v_l[k] = locked[1];
            step();
        end
        check("b_tick_seq", 32'(v_t), 32'h14);
        check("b_square_seq", 32'(v_s), 32'h09);
        check("b_ready_seq", 32'(v_r), 32'h18);
        check("b_locked_seq", 32'(v_l), 32'h07);

        // transfer on ch0's wrap cycle waits for the following wrap
        wait_tick(0);
        send(0, 2, 0);
        v_t = '0; v_r = '0;
        for (int k = 0; k < 6; k++) begin
            v_t[k] = tick[0];
            v_r[k] = cfg_ready;
            step();
        end
        check("c_tick_seq", 32'(v_t), 32'h28);
        check("c_ready_seq", 32'(v_r), 32'h30);

        // phase >= div starts at 0; second request waits for the first
        send(3, 4, 7);
        check("d_ready_busy", 32'(cfg_ready), 32'h0);
        send(2, 1, 0);
        v_t = '0; v_s = '0;
        for (int k = 0; k < 3; k++) begin
            v_t[k] = tick[3];
            v_s[k] = square[3];
            step();
        end
        check("d_tick3_seq", 32'(v_t), 32'h4);
        check("d_square3_seq", 32'(v_s), 32'h1);
        v_t = '0; v_s = '0;
        for (int k = 0; k < 3; k++) begin
            v_t[k] = tick[2];
            v_s[k] = square[2];
            step();
        end
        check("d_div1_tick", 32'(v_t), 32'h7);
        check("d_div1_square", 32'(v_s), 32'h7);
        repeat (12) step();
        send(2, 0, 0);
        v_t = '0;
        for (int k = 0; k < 2; k++) begin
            v_t[k] = tick[2];
            step();
        end
        check("d_off_tick_seq", 32'(v_t), 32'h1);
        check("d_off_square", 32'(square[2]), 32'h0);
        check("d_off_locked", 32'(locked[2]), 32'h0);
        repeat (20) step();

        // reset while an update is pending
        send(1, 6, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("e_tick", 32'(tick), 32'h0);
        check("e_square", 32'(square), 32'h0);
        check("e_locked", 32'(locked), 32'h0);
        check("e_all_locked", 32'(all_locked), 32'h0);
        check("e_cfg_ready", 32'(cfg_ready), 32'h1);
        repeat (5) step();
        check("e_still_off", 32'(square), 32'h0);

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
